// File: rtl/forward_data_path_pkg.sv
// Shared definitions for the forwarding data path.
//   FWD_SEL_*  : forwarding select encodings (regular, PC-4, PC-8, PC-12)
//   fwd_slot_t : one result-history slot {data, pending}
package forward_data_path_pkg;

  localparam logic [1:0] FWD_SEL_REG  = 2'd0;
  localparam logic [1:0] FWD_SEL_PC4  = 2'd1;
  localparam logic [1:0] FWD_SEL_PC8  = 2'd2;
  localparam logic [1:0] FWD_SEL_PC12 = 2'd3;

  typedef struct packed {
    logic [31:0] data;
    logic        pending;
  } fwd_slot_t;

endpackage

// File: rtl/forward_data_path_fwd_mux4.sv
// 4:1 32-bit forwarding operand select.
// Ports:
//   sel       : forwarding select (FWD_SEL_*)
//   reg_data  : register-file value (select 0)
//   pc4_data  : PC-4 result, already load-bypassed (select 1)
//   pc8_data  : PC-8 result (select 2)
//   pc12_data : PC-12 result (select 3)
//   result    : selected operand
module fwd_mux4
  import forward_data_path_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [31:0] reg_data,
  input  logic [31:0] pc4_data,
  input  logic [31:0] pc8_data,
  input  logic [31:0] pc12_data,
  output logic [31:0] result
);

  always_comb begin
    result = reg_data;
    case (sel)
      FWD_SEL_PC4:  result = pc4_data;
      FWD_SEL_PC8:  result = pc8_data;
      FWD_SEL_PC12: result = pc12_data;
      default:      result = reg_data;
    endcase
  end

endmodule

// File: rtl/forward_data_path.sv
// Forwarding data path: 3-slot result history (PC-4, PC-8, PC-12) with
// load patching, same-cycle load bypass and load-use stall detection.
// Ports:
//   CLK, RESET (sync, active-low), STALL (history freeze)
//   EXE_Result/EXE_Writes/EXE_Is_Load : result entering the history
//   MEM_Load_Data/MEM_Load_Valid      : late load data for a pending slot1
//   *_Select / Reg_*                  : per-operand select and register value
//   Fwd_*                             : forwarded operands (combinational)
//   Load_Use_Stall                    : a PC-4 forward is still waiting on load data
// Optional (macro FWD_DATA_STATS_EN): Fwd_Count, Load_Stall_Count statistics.
module forward_data_path
  import forward_data_path_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic [31:0] EXE_Result,
  input  logic        EXE_Writes,
  input  logic        EXE_Is_Load,
  input  logic [31:0] MEM_Load_Data,
  input  logic        MEM_Load_Valid,
  input  logic [1:0]  EXE_A_Select,
  input  logic [1:0]  EXE_B_Select,
  input  logic [1:0]  MEM_Data_select,
  input  logic [1:0]  Branch_JR_select_A,
  input  logic [1:0]  Branch_JR_select_B,
  input  logic [31:0] Reg_A,
  input  logic [31:0] Reg_B,
  input  logic [31:0] Reg_MEM_Data,
  input  logic [31:0] Reg_Branch_A,
  input  logic [31:0] Reg_Branch_B,
  output logic [31:0] Fwd_A,
  output logic [31:0] Fwd_B,
  output logic [31:0] Fwd_MEM_Data,
  output logic [31:0] Fwd_Branch_A,
  output logic [31:0] Fwd_Branch_B,
  output logic        Load_Use_Stall
`ifdef FWD_DATA_STATS_EN
  ,
  output logic [31:0] Fwd_Count,
  output logic [31:0] Load_Stall_Count
`endif
);

  fwd_slot_t   slot1, slot2, slot3;
  logic        load_patch;
  logic [31:0] pc4_data;
  logic [4:0]  waiting;

  // Load data arriving for slot1 is both bypassed to consumers and written
  // into the history (slot1 when frozen, slot2 when shifting).
  assign load_patch = slot1.pending & MEM_Load_Valid;
  assign pc4_data   = load_patch ? MEM_Load_Data : slot1.data;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      slot1 <= '0;
      slot2 <= '0;
      slot3 <= '0;
    end else if (!STALL) begin
      slot3 <= slot2;
      // An unpatched pending load is passed on as-is but no longer pending.
      slot2 <= '{data: pc4_data, pending: 1'b0};
      slot1 <= '{data:    EXE_Writes ? EXE_Result : 32'h0,
                 pending: EXE_Writes & EXE_Is_Load};
    end else if (load_patch) begin
      slot1 <= '{data: MEM_Load_Data, pending: 1'b0};
    end
  end

  // Slots 2 and 3 are never pending, so those terms are constant zero; they
  // keep the pending bit meaning the same for every slot.
  function automatic logic wait_hit(input logic [1:0] sel, input fwd_slot_t s1,
                                    input fwd_slot_t s2, input fwd_slot_t s3,
                                    input logic valid);
    return ((sel == FWD_SEL_PC4)  & s1.pending & ~valid) |
           ((sel == FWD_SEL_PC8)  & s2.pending) |
           ((sel == FWD_SEL_PC12) & s3.pending);
  endfunction

  assign waiting[0] = wait_hit(EXE_A_Select,       slot1, slot2, slot3, MEM_Load_Valid);
  assign waiting[1] = wait_hit(EXE_B_Select,       slot1, slot2, slot3, MEM_Load_Valid);
  assign waiting[2] = wait_hit(MEM_Data_select,    slot1, slot2, slot3, MEM_Load_Valid);
  assign waiting[3] = wait_hit(Branch_JR_select_A, slot1, slot2, slot3, MEM_Load_Valid);
  assign waiting[4] = wait_hit(Branch_JR_select_B, slot1, slot2, slot3, MEM_Load_Valid);
  assign Load_Use_Stall = |waiting;

  fwd_mux4 u_mux_a (
    .sel(EXE_A_Select), .reg_data(Reg_A), .pc4_data(pc4_data),
    .pc8_data(slot2.data), .pc12_data(slot3.data), .result(Fwd_A));
  fwd_mux4 u_mux_b (
    .sel(EXE_B_Select), .reg_data(Reg_B), .pc4_data(pc4_data),
    .pc8_data(slot2.data), .pc12_data(slot3.data), .result(Fwd_B));
  fwd_mux4 u_mux_mem (
    .sel(MEM_Data_select), .reg_data(Reg_MEM_Data), .pc4_data(pc4_data),
    .pc8_data(slot2.data), .pc12_data(slot3.data), .result(Fwd_MEM_Data));
  fwd_mux4 u_mux_br_a (
    .sel(Branch_JR_select_A), .reg_data(Reg_Branch_A), .pc4_data(pc4_data),
    .pc8_data(slot2.data), .pc12_data(slot3.data), .result(Fwd_Branch_A));
  fwd_mux4 u_mux_br_b (
    .sel(Branch_JR_select_B), .reg_data(Reg_Branch_B), .pc4_data(pc4_data),
    .pc8_data(slot2.data), .pc12_data(slot3.data), .result(Fwd_Branch_B));

`ifdef FWD_DATA_STATS_EN
  logic any_fwd;

  assign any_fwd = (EXE_A_Select       != FWD_SEL_REG) |
                   (EXE_B_Select       != FWD_SEL_REG) |
                   (MEM_Data_select    != FWD_SEL_REG) |
                   (Branch_JR_select_A != FWD_SEL_REG) |
                   (Branch_JR_select_B != FWD_SEL_REG);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      Fwd_Count        <= '0;
      Load_Stall_Count <= '0;
    end else begin
      if (!STALL && any_fwd) Fwd_Count <= Fwd_Count + 32'd1;
      if (Load_Use_Stall)    Load_Stall_Count <= Load_Stall_Count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_forward_data_path.sv
module tb_forward_data_path;
  import forward_data_path_pkg::*;

  logic        CLK, RESET, STALL;
  logic [31:0] EXE_Result;
  logic        EXE_Writes, EXE_Is_Load;
  logic [31:0] MEM_Load_Data;
  logic        MEM_Load_Valid;
  logic [1:0]  EXE_A_Select, EXE_B_Select, MEM_Data_select, Branch_JR_select_A, Branch_JR_select_B;
  logic [31:0] Reg_A, Reg_B, Reg_MEM_Data, Reg_Branch_A, Reg_Branch_B;
  logic [31:0] Fwd_A, Fwd_B, Fwd_MEM_Data, Fwd_Branch_A, Fwd_Branch_B;
  logic        Load_Use_Stall;
`ifdef FWD_DATA_STATS_EN
  logic [31:0] Fwd_Count, Load_Stall_Count;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  // reference history
  logic [31:0] m_d1, m_d2, m_d3;
  logic        m_p1;

  forward_data_path dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL),
    .EXE_Result(EXE_Result), .EXE_Writes(EXE_Writes), .EXE_Is_Load(EXE_Is_Load),
    .MEM_Load_Data(MEM_Load_Data), .MEM_Load_Valid(MEM_Load_Valid),
    .EXE_A_Select(EXE_A_Select), .EXE_B_Select(EXE_B_Select),
    .MEM_Data_select(MEM_Data_select),
    .Branch_JR_select_A(Branch_JR_select_A), .Branch_JR_select_B(Branch_JR_select_B),
    .Reg_A(Reg_A), .Reg_B(Reg_B), .Reg_MEM_Data(Reg_MEM_Data),
    .Reg_Branch_A(Reg_Branch_A), .Reg_Branch_B(Reg_Branch_B),
    .Fwd_A(Fwd_A), .Fwd_B(Fwd_B), .Fwd_MEM_Data(Fwd_MEM_Data),
    .Fwd_Branch_A(Fwd_Branch_A), .Fwd_Branch_B(Fwd_Branch_B),
    .Load_Use_Stall(Load_Use_Stall)
`ifdef FWD_DATA_STATS_EN
    , .Fwd_Count(Fwd_Count), .Load_Stall_Count(Load_Stall_Count)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance one clock, updating the reference history from the inputs
  // currently driven (they are held stable up to the edge).
  task automatic tick();
    if (!RESET) begin
      m_d1 = '0; m_d2 = '0; m_d3 = '0; m_p1 = 1'b0;
    end else if (!STALL) begin
      m_d3 = m_d2;
      m_d2 = (m_p1 && MEM_Load_Valid) ? MEM_Load_Data : m_d1;
      m_d1 = EXE_Writes ? EXE_Result : 32'h0;
      m_p1 = EXE_Writes && EXE_Is_Load;
    end else if (m_p1 && MEM_Load_Valid) begin
      m_d1 = MEM_Load_Data;
      m_p1 = 1'b0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    STALL = 0; EXE_Result = '0; EXE_Writes = 0; EXE_Is_Load = 0;
    MEM_Load_Data = '0; MEM_Load_Valid = 0;
    EXE_A_Select = 0; EXE_B_Select = 0; MEM_Data_select = 0;
    Branch_JR_select_A = 0; Branch_JR_select_B = 0;
    Reg_A = 32'hA0A0_0001; Reg_B = 32'hB0B0_0002; Reg_MEM_Data = 32'hC0C0_0003;
    Reg_Branch_A = 32'hD0D0_0004; Reg_Branch_B = 32'hE0E0_0005;
  endtask

  task automatic test_reset();
    RESET = 0; idle_inputs();
    tick();
    RESET = 1; EXE_Writes = 1; EXE_Is_Load = 1; EXE_Result = 32'h0000_4444;
    tick();
    RESET = 0; EXE_Writes = 0; EXE_Is_Load = 0; EXE_A_Select = 1; EXE_B_Select = 0;
    tick();
    tick();
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(Reg_B); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); total++;
    if (Fwd_A !== e) begin bad++; $display("FAIL reset_fwd_a: got %h want %h", Fwd_A, e); end
    e = exp_q.pop_front(); total++;
    if (Fwd_B !== e) begin bad++; $display("FAIL reset_fwd_b_reg: got %h want %h", Fwd_B, e); end
    e = exp_q.pop_front(); total++;
    if ({31'h0, Load_Use_Stall} !== e) begin bad++; $display("FAIL reset_stall: got %b want %h", Load_Use_Stall, e); end
    // first cycle after reset: load valid with nothing pending is ignored
    RESET = 1; MEM_Load_Valid = 1; MEM_Load_Data = 32'h0000_0BAD; STALL = 1;
    #1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); total++;
    if (Fwd_A !== e) begin bad++; $display("FAIL post_reset_valid_fwd_a: got %h want %h", Fwd_A, e); end
    e = exp_q.pop_front(); total++;
    if ({31'h0, Load_Use_Stall} !== e) begin bad++; $display("FAIL post_reset_valid_stall: got %b want %h", Load_Use_Stall, e); end
    tick();
    MEM_Load_Valid = 0; STALL = 0;
    #1;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); total++;
    if (Fwd_A !== e) begin bad++; $display("FAIL post_reset_no_patch: got %h want %h", Fwd_A, e); end
  endtask

  task automatic test_alu_chain();
    idle_inputs(); EXE_Writes = 1;
    EXE_Result = 32'h11; tick();
    EXE_Result = 32'h22; tick();
    EXE_Result = 32'h33; tick();
    EXE_Writes = 0; EXE_Result = 32'hFFFF_FFFF;
    EXE_A_Select = 1; EXE_B_Select = 2; MEM_Data_select = 3;
    #1;
    exp_q.push_back(32'h33); exp_q.push_back(32'h22); exp_q.push_back(32'h11);
    exp_q.push_back(Reg_Branch_A);
    e = exp_q.pop_front(); total++;
    if (Fwd_A !== e) begin bad++; $display("FAIL alu_fwd_a: got %h want %h", Fwd_A, e); end
    e = exp_q.pop_front(); total++;
    if (Fwd_B !== e) begin bad++; $display("FAIL alu_fwd_b: got %h want %h", Fwd_B, e); end
    e = exp_q.pop_front(); total++;
    if (Fwd_MEM_Data !== e) begin bad++; $display("FAIL alu_fwd_mem: got %h want %h", Fwd_MEM_Data, e); end
    e = exp_q.pop_front(); total++;
    if (Fwd_Branch_A !== e) begin bad++; $display("FAIL alu_branch_reg: got %h want %h", Fwd_Branch_A, e); end
  endtask

  task automatic test_load_use();
    idle_inputs(); EXE_Writes = 1; EXE_Is_Load = 1; EXE_Result = 32'h5555_0000;
    tick();
    EXE_Writes = 0; EXE_Is_Load = 0; EXE_A_Select = 1; STALL = 1;
    #1;
    exp_q.push_back(32'h1); exp_q.push_back(32'h5555_0000);
    e = exp_q.pop_front(); total++;
    if ({31'h0, Load_Use_Stall} !== e) begin bad++; $display("FAIL load_use_stall: got %b want %h", Load_Use_Stall, e); end
    e = exp_q.pop_front(); total++;
    if (Fwd_A !== e) begin bad++; $display("FAIL load_use_slot1_data: got %h want %h", Fwd_A, e); end
    tick();
    MEM_Load_Valid = 1; MEM_Load_Data = 32'hDEAD_BEEF;
    #1;
    exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); total++;
    if (Fwd_A !== e) begin bad++; $display("FAIL load_bypass_fwd_a: got %h want %h", Fwd_A, e); end
    e = exp_q.pop_front(); total++;
    if ({31'h0, Load_Use_Stall} !== e) begin bad++; $display("FAIL load_bypass_stall: got %b want %h", Load_Use_Stall, e); end
    tick();
    MEM_Load_Valid = 0; MEM_Load_Data = 32'h0; STALL = 0;
    #1;
    exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); total++;
    if (Fwd_A !== e) begin bad++; $display("FAIL load_patch_slot1: got %h want %h", Fwd_A, e); end
    e = exp_q.pop_front(); total++;
    if ({31'h0, Load_Use_Stall} !== e) begin bad++; $display("FAIL load_patch_stall: got %b want %h", Load_Use_Stall, e); end
  endtask

  task automatic test_bypass_shift();
    idle_inputs(); EXE_Writes = 1; EXE_Is_Load = 1; EXE_Result = 32'h0000_1234;
    tick();
    EXE_Writes = 0; EXE_Is_Load = 0; EXE_B_Select = 1;
    MEM_Load_Valid = 1; MEM_Load_Data = 32'h0000_CAFE;
    #1;
    exp_q.push_back(32'h0000_CAFE);
    e = exp_q.pop_front(); total++;
    if (Fwd_B !== e) begin bad++; $display("FAIL bypass_fwd_b: got %h want %h", Fwd_B, e); end
    tick();
    MEM_Load_Valid = 0; MEM_Load_Data = 32'h0; EXE_B_Select = 2; EXE_A_Select = 1;
    #1;
    exp_q.push_back(32'h0000_CAFE); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); total++;
    if (Fwd_B !== e) begin bad++; $display("FAIL shifted_patch_slot2: got %h want %h", Fwd_B, e); end
    e = exp_q.pop_front(); total++;
    if (Fwd_A !== e) begin bad++; $display("FAIL shifted_slot1_zero: got %h want %h", Fwd_A, e); end
  endtask

  task automatic test_unpatched_shift();
    idle_inputs(); EXE_Writes = 1; EXE_Is_Load = 1; EXE_Result = 32'h0000_0077;
    tick();
    EXE_Writes = 0; EXE_Is_Load = 0;
    tick();
    EXE_A_Select = 2; EXE_B_Select = 1;
    #1;
    exp_q.push_back(32'h0000_0077); exp_q.push_back(32'h0);
    e = exp_q.pop_front(); total++;
    if (Fwd_A !== e) begin bad++; $display("FAIL unpatched_slot2_data: got %h want %h", Fwd_A, e); end
    e = exp_q.pop_front(); total++;
    if ({31'h0, Load_Use_Stall} !== e) begin bad++; $display("FAIL unpatched_no_stall: got %b want %h", Load_Use_Stall, e); end
  endtask

  task automatic test_stall_hold();
    idle_inputs(); EXE_Writes = 1;
    EXE_Result = 32'hA1; tick();
    EXE_Result = 32'hA2; tick();
    EXE_Result = 32'hA3; tick();
    STALL = 1; EXE_Is_Load = 1;
    for (int i = 0; i < 3; i++) begin
      EXE_Result = 32'hF000_0000 + 32'(i);
      tick();
    end
    EXE_Is_Load = 0;
    EXE_A_Select = 1; EXE_B_Select = 2; MEM_Data_select = 3;
    #1;
    exp_q.push_back(32'hA3); exp_q.push_back(32'hA2); exp_q.push_back(32'hA1);
    e = exp_q.pop_front(); total++;
    if (Fwd_A !== e) begin bad++; $display("FAIL stall_hold_slot1: got %h want %h", Fwd_A, e); end
    e = exp_q.pop_front(); total++;
    if (Fwd_B !== e) begin bad++; $display("FAIL stall_hold_slot2: got %h want %h", Fwd_B, e); end
    e = exp_q.pop_front(); total++;
    if (Fwd_MEM_Data !== e) begin bad++; $display("FAIL stall_hold_slot3: got %h want %h", Fwd_MEM_Data, e); end
    STALL = 0; EXE_Result = 32'hB0;
    tick();
    Branch_JR_select_A = 1; Branch_JR_select_B = 3;
    #1;
    exp_q.push_back(32'hB0); exp_q.push_back(32'hA2);
    e = exp_q.pop_front(); total++;
    if (Fwd_Branch_A !== e) begin bad++; $display("FAIL release_branch_a: got %h want %h", Fwd_Branch_A, e); end
    e = exp_q.pop_front(); total++;
    if (Fwd_Branch_B !== e) begin bad++; $display("FAIL release_branch_b: got %h want %h", Fwd_Branch_B, e); end
  endtask

  function automatic logic [31:0] model_fwd(input logic [1:0] sel, input logic [31:0] regv);
    case (sel)
      2'd0:    return regv;
      2'd1:    return (m_p1 && MEM_Load_Valid) ? MEM_Load_Data : m_d1;
      2'd2:    return m_d2;
      default: return m_d3;
    endcase
  endfunction

  task automatic test_random();
    logic exp_stall;
    for (int n = 0; n < 300; n++) begin
      RESET = ($urandom_range(0, 19) != 0);
      STALL = ($urandom_range(0, 3) == 0);
      EXE_Result = $urandom(); EXE_Writes = $urandom_range(0, 1); EXE_Is_Load = $urandom_range(0, 1);
      MEM_Load_Data = $urandom(); MEM_Load_Valid = $urandom_range(0, 1);
      EXE_A_Select = 2'($urandom_range(0, 3)); EXE_B_Select = 2'($urandom_range(0, 3));
      MEM_Data_select = 2'($urandom_range(0, 3));
      Branch_JR_select_A = 2'($urandom_range(0, 3)); Branch_JR_select_B = 2'($urandom_range(0, 3));
      Reg_A = $urandom(); Reg_B = $urandom(); Reg_MEM_Data = $urandom();
      Reg_Branch_A = $urandom(); Reg_Branch_B = $urandom();
      #1;
      exp_stall = m_p1 && !MEM_Load_Valid &&
                  (EXE_A_Select == 1 || EXE_B_Select == 1 || MEM_Data_select == 1 ||
                   Branch_JR_select_A == 1 || Branch_JR_select_B == 1);
      exp_q.push_back(model_fwd(EXE_A_Select, Reg_A));
      exp_q.push_back(model_fwd(EXE_B_Select, Reg_B));
      exp_q.push_back(model_fwd(MEM_Data_select, Reg_MEM_Data));
      exp_q.push_back(model_fwd(Branch_JR_select_A, Reg_Branch_A));
      exp_q.push_back(model_fwd(Branch_JR_select_B, Reg_Branch_B));
      exp_q.push_back({31'h0, exp_stall});
      e = exp_q.pop_front(); total++;
      if (Fwd_A !== e) begin bad++; $display("FAIL rand_fwd_a[%0d]: got %h want %h", n, Fwd_A, e); end
      e = exp_q.pop_front(); total++;
      if (Fwd_B !== e) begin bad++; $display("FAIL rand_fwd_b[%0d]: got %h want %h", n, Fwd_B, e); end
      e = exp_q.pop_front(); total++;
      if (Fwd_MEM_Data !== e) begin bad++; $display("FAIL rand_fwd_mem[%0d]: got %h want %h", n, Fwd_MEM_Data, e); end
      e = exp_q.pop_front(); total++;
      if (Fwd_Branch_A !== e) begin bad++; $display("FAIL rand_branch_a[%0d]: got %h want %h", n, Fwd_Branch_A, e); end
      e = exp_q.pop_front(); total++;
      if (Fwd_Branch_B !== e) begin bad++; $display("FAIL rand_branch_b[%0d]: got %h want %h", n, Fwd_Branch_B, e); end
      e = exp_q.pop_front(); total++;
      if ({31'h0, Load_Use_Stall} !== e) begin bad++; $display("FAIL rand_stall[%0d]: got %b want %h", n, Load_Use_Stall, e); end
      tick();
    end
    RESET = 1;
  endtask

`ifdef FWD_DATA_STATS_EN
  task automatic test_stats();
    idle_inputs(); RESET = 0;
    tick(); tick();
    RESET = 1;
    #1;
    exp_q.push_back(32'd0);
    e = exp_q.pop_front(); total++;
    if (Fwd_Count !== e) begin bad++; $display("FAIL stats_reset_fwd: got %0d want %0d", Fwd_Count, e); end
    EXE_A_Select = 2;
    for (int i = 0; i < 5; i++) tick();
    EXE_A_Select = 0; EXE_Writes = 1; EXE_Is_Load = 1; EXE_Result = 32'h0000_0100;
    tick();
    EXE_Writes = 0; EXE_Is_Load = 0; STALL = 1; EXE_A_Select = 1;
    tick(); tick();
    EXE_A_Select = 0; STALL = 0;
    #1;
    exp_q.push_back(32'd5); exp_q.push_back(32'd2);
    e = exp_q.pop_front(); total++;
    if (Fwd_Count !== e) begin bad++; $display("FAIL stats_fwd_count: got %0d want %0d", Fwd_Count, e); end
    e = exp_q.pop_front(); total++;
    if (Load_Stall_Count !== e) begin bad++; $display("FAIL stats_load_stall_count: got %0d want %0d", Load_Stall_Count, e); end
  endtask
`endif

  initial begin
    m_d1 = '0; m_d2 = '0; m_d3 = '0; m_p1 = 1'b0;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_bypass_shift();
    test_unpatched_shift();
    test_stall_hold();
    test_random();
`ifdef FWD_DATA_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/forward_data_path.md
FORWARD_DATA_PATH -- requirements
Module: forward_data_path

Interface
REQ-001 SHALL provide the following ports:
- CLK  in  1  pipeline clock; all state updates on posedge.
- RESET  in  1  reset; synchronous, active-low.
- STALL  in  1  pipeline freeze; history holds when 1.
- EXE_Result  in  32  ALU/link result of the instruction currently in EXE.
- EXE_Writes  in  1  EXE instruction writes a register (non-zero rd).
- EXE_Is_Load  in  1  EXE instruction is a load; its result is not final until MEM.
- MEM_Load_Data  in  32  load data returned in MEM.
- MEM_Load_Valid  in  1  MEM_Load_Data valid this cycle.
- EXE_A_Select, EXE_B_Select, MEM_Data_select, Branch_JR_select_A, Branch_JR_select_B  in  2 each  forwarding selects: 0 = regular, 1 = PC-4, 2 = PC-8, 3 = PC-12.
- Reg_A, Reg_B, Reg_MEM_Data, Reg_Branch_A, Reg_Branch_B  in  32 each  register-file values.
- Fwd_A, Fwd_B, Fwd_MEM_Data, Fwd_Branch_A, Fwd_Branch_B  out  32 each  forwarded operands.
- Load_Use_Stall  out  1  forwarded value not yet available.

Function
REQ-002 SHALL hold a 3-slot result history. Slot1 = PC-4, slot2 = PC-8, slot3 = PC-12. Each slot holds data[31:0] and a pending bit.
REQ-003 On a posedge with STALL=0, the history SHALL shift:
- slot3 <= slot2.
- slot2 <= slot1.
- slot1 <= {EXE_Writes ? EXE_Result : 0, pending = EXE_Writes & EXE_Is_Load}.
REQ-004 MEM_Load_Valid=1 with slot1.pending=1 SHALL patch the load:
- If shifting: slot2 receives MEM_Load_Data with pending=0.
- If STALL=1: slot1 receives MEM_Load_Data with pending=0.
REQ-005 MEM_Load_Valid with slot1.pending=0 SHALL be ignored.
REQ-006 Each output SHALL be a combinational mux of its own select:
- 0 -> matching Reg_* input.
- 1 -> slot1 data.
- 2 -> slot2 data.
- 3 -> slot3 data.
- Latency: 0 cycles.
REQ-007 Select=1 with slot1.pending=1 and MEM_Load_Valid=1 SHALL output MEM_Load_Data (same-cycle bypass).
REQ-008 Load_Use_Stall SHALL be 1 iff any select=1, slot1.pending=1 and MEM_Load_Valid=0. In that case the affected outputs SHALL show slot1 data (don't-care to consumers).
REQ-009 STALL=1 SHALL hold all slots except the REQ-004 patch. Outputs remain combinational during STALL.
REQ-010 Slots 2 and 3 SHALL never be pending. A pending slot1 shifted without a patch SHALL be cleared to pending=0 in slot2 (upstream protocol error; data passed unchanged).

Reset
REQ-011 RESET=0 at posedge SHALL clear all slot data and pending bits to 0. Reset SHALL take priority over STALL and patching.
REQ-012 During and after reset, outputs SHALL equal the Reg_* inputs when selects are 0 and 32'h0 when selects are non-zero. Load_Use_Stall SHALL be 0.
REQ-013 Reset asserted mid-load (slot1 pending) SHALL discard the pending load. A MEM_Load_Valid in the first cycle after reset SHALL be ignored.

Configuration
REQ-014 Macro FWD_DATA_STATS_EN SHALL control statistics.
- Defined: add outputs Fwd_Count[31:0] and Load_Stall_Count[31:0].
- Fwd_Count increments once per non-stalled cycle in which any select is non-zero.
- Load_Stall_Count increments each cycle Load_Use_Stall=1.
- Both counters wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; function is otherwise identical.

Structure
REQ-015 A shared package SHALL define:
- The select encodings FWD_SEL_REG=0, FWD_SEL_PC4=1, FWD_SEL_PC8=2, FWD_SEL_PC12=3.
- The slot struct type {data, pending}.
REQ-016 One sub-module, fwd_mux4, SHALL implement the 4:1 32-bit select, instantiated five times. History and stall logic stay in the top module.

Verification
REQ-017 Verification SHALL cover these directed scenarios:
- Reset: RESET=0 for 2 cycles, then EXE_A_Select=1 -> Fwd_A=0, Load_Use_Stall=0.
- ALU chain: results 0x11, 0x22, 0x33 over 3 cycles with EXE_Writes=1; then selects A=1, B=2, MEM=3 -> Fwd_A=0x33, Fwd_B=0x22, Fwd_MEM_Data=0x11.
- Load-use: load enters slot1, EXE_A_Select=1 with MEM_Load_Valid=0 -> Load_Use_Stall=1. Next cycle with STALL=1 and MEM_Load_Valid=1, data 0xDEADBEEF -> Fwd_A=0xDEADBEEF, Load_Use_Stall=0.
- Bypass plus shift: slot1 pending, MEM_Load_Valid=1 with data 0xCAFE, STALL=0 -> same-cycle Fwd_B (select 1)=0xCAFE. Next cycle select 2 -> 0xCAFE.
- Stall hold: STALL=1 for 3 cycles while EXE_Result changes -> slot contents unchanged.
- Stats (FWD_DATA_STATS_EN): 5 forwarding cycles plus 2 load-stall cycles -> Fwd_Count=5, Load_Stall_Count=2.
